// File: rtl/sram_port_arbiter.sv
// Arbitrates the shared image SRAM between video, a writer and a single-word reader.
// Video has priority. A starvation counter forces a writer/reader grant after STARVE_LIMIT waits.
module sram_port_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr_a,
  input  logic [ADDR_WIDTH-1:0] vid_addr_b,
  output logic                  vid_gnt,
  output logic                  vid_rvalid,
  output logic [DATA_WIDTH-1:0] vid_data_a,
  output logic [DATA_WIDTH-1:0] vid_data_b,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  output logic [ADDR_WIDTH-1:0] sram_addr2,
  output logic [DATA_WIDTH-1:0] sram_data_i,
  input  logic [DATA_WIDTH-1:0] sram_data_o1,
  input  logic [DATA_WIDTH-1:0] sram_data_o2
);

  localparam logic RR_WR = 1'b0;
  localparam logic RR_RD = 1'b1;

  logic                  rr_ptr_q, rr_ptr_d;
  logic [7:0]            starve_cnt_q, starve_cnt_d;
  logic                  vid_tag_q, rd_tag_q;
  logic [ADDR_WIDTH-1:0] addr1_q, addr2_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q, rd_data_q;

  logic low_req, pick_rd, starved, low_sel;

  // Grants depend only on requests and registered state, never on SRAM read data.
  always_comb begin
    low_req = wr_req | rd_req;
    pick_rd = rd_req & (~wr_req | (rr_ptr_q == RR_RD));
    starved = low_req & (starve_cnt_q == 8'(STARVE_LIMIT));
    low_sel = low_req & (starved | ~vid_req);
    // NOTE: grants are gated by reset_n so the SRAM is released the instant reset asserts,
    // not at the next clock edge.
    vid_gnt = reset_n & vid_req & ~starved;
    wr_gnt  = reset_n & low_sel & ~pick_rd;
    rd_gnt  = reset_n & low_sel & pick_rd;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (wr_gnt | rd_gnt | ~low_req) starve_cnt_d = 8'd0;
    else if (vid_gnt)               starve_cnt_d = starve_cnt_q + 8'd1;

    rr_ptr_d = rr_ptr_q;
    if (wr_gnt)      rr_ptr_d = RR_RD;
    else if (rd_gnt) rr_ptr_d = RR_WR;
  end

  // Idle address/data lines keep the last driven value to avoid needless toggling.
  always_comb begin
    sram_en     = vid_gnt | wr_gnt | rd_gnt;
    sram_we     = wr_gnt;
    sram_addr1  = addr1_q;
    sram_addr2  = addr2_q;
    sram_data_i = wdata_q;
    if (vid_gnt) begin
      sram_addr1 = vid_addr_a;
      sram_addr2 = vid_addr_b;
    end else if (wr_gnt) begin
      sram_addr1  = wr_addr;
      sram_data_i = wr_data;
    end else if (rd_gnt) begin
      sram_addr1 = rd_addr;
    end
  end

  assign vid_rvalid = vid_tag_q;
  assign rd_rvalid  = rd_tag_q;
  assign vid_data_a = vid_tag_q ? sram_data_o1 : data_a_q;
  assign vid_data_b = vid_tag_q ? sram_data_o2 : data_b_q;
  assign rd_data    = rd_tag_q  ? sram_data_o1 : rd_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= RR_WR;
      starve_cnt_q <= 8'd0;
      vid_tag_q    <= 1'b0;
      rd_tag_q     <= 1'b0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      wdata_q      <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      vid_tag_q    <= vid_gnt;
      rd_tag_q     <= rd_gnt;
      addr1_q      <= sram_addr1;
      addr2_q      <= sram_addr2;
      wdata_q      <= sram_data_i;
      if (vid_tag_q) begin
        data_a_q <= sram_data_o1;
        data_b_q <= sram_data_o2;
      end
      if (rd_tag_q) rd_data_q <= sram_data_o1;
    end
  end

endmodule
